// File: rtl/register_read.sv
// -----------------------------------------------------------------------------
// register_read
//
// AXI-Lite slave exposing two banks of 32-bit words inside one address window:
//   offset 0x00 + 4*i : statistics word i (read-only, sampled live)
//   offset 0x40 + 4*i : host word i (read/write, driven out on host_data)
// Only addresses whose bits [31:REG_ADDR_W] equal REG_PREFIX reach the block.
// Writes are full-word only (there are no strobes).
//
// Optional feature macro: REGISTER_READ_ERR_RESP_EN
//   defined     : misses and writes to statistics respond SLVERR, prefix
//                 mismatches respond DECERR, hits respond OKAY.
//   not defined : every response is OKAY; data behaviour is identical.
//
// Parameters
//   REG_ADDR_W : number of low address bits decoded inside the window
//   NUMBER_REG : number of statistics words and of host words (1..16)
//   REG_PREFIX : required value of address bits [31:REG_ADDR_W]
//
// Ports
//   aclk                    : sole clock, rising edge
//   aresetn                 : asynchronous reset, asserted HIGH despite the name
//   s_axil_aw* / s_axil_w*  : write address / write data channels
//   s_axil_b*               : write response channel
//   s_axil_ar*              : read address channel
//   s_axil_r*               : read data channel
//   statstics               : live statistics, word i = bits [32i+31:32i]
//   host_data               : host-written words, word i = bits [32i+31:32i]
// -----------------------------------------------------------------------------
module register_read #(
  parameter int REG_ADDR_W = 12,
  parameter int NUMBER_REG = 10,
  parameter int REG_PREFIX = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,

  input  logic                    s_axil_awvalid,
  input  logic [31:0]             s_axil_awaddr,
  output logic                    s_axil_awready,

  input  logic                    s_axil_wvalid,
  input  logic [31:0]             s_axil_wdata,
  output logic                    s_axil_wready,

  output logic                    s_axil_bvalid,
  output logic [1:0]              s_axil_bresp,
  input  logic                    s_axil_bready,

  input  logic                    s_axil_arvalid,
  input  logic [31:0]             s_axil_araddr,
  output logic                    s_axil_arready,

  output logic                    s_axil_rvalid,
  output logic [31:0]             s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  input  logic                    s_axil_rready,

  input  logic [32*NUMBER_REG-1:0] statstics,
  output logic [32*NUMBER_REG-1:0] host_data
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Address window masks. The prefix is compared in place (already shifted)
  // so no width juggling is needed between the parameter and the address.
  localparam logic [31:0] LOW_MASK    = (32'd1 << REG_ADDR_W) - 32'd1;
  localparam logic [31:0] PREFIX_BITS = 32'(REG_PREFIX) << REG_ADDR_W;
  localparam logic [31:0] STAT_END    = 32'(4 * NUMBER_REG);
  localparam logic [31:0] HOST_BASE   = 32'h40;
  localparam logic [31:0] HOST_END    = HOST_BASE + STAT_END;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACCEPT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACCEPT,
    R_RESP
  } rd_state_t;

  // Word-aligned offset inside the window (addr[1:0] ignored).
  function automatic logic [31:0] offset_of(input logic [31:0] addr);
    return addr & LOW_MASK & ~32'h3;
  endfunction

  function automatic logic prefix_match(input logic [31:0] addr);
    return (addr & ~LOW_MASK) == PREFIX_BITS;
  endfunction

  wr_state_t   wr_state;
  wr_state_t   wr_next;
  rd_state_t   rd_state;
  rd_state_t   rd_next;

  logic [31:0] host_regs  [NUMBER_REG];
  logic [31:0] stat_words [NUMBER_REG];

  logic [31:0] wr_off;
  logic        wr_prefix_ok;
  logic        wr_host_hit;
  logic [3:0]  wr_idx;
  logic        wr_fire;
  logic [1:0]  wr_resp;

  logic [31:0] rd_off;
  logic        rd_prefix_ok;
  logic        rd_stat_hit;
  logic        rd_host_hit;
  logic [3:0]  rd_idx;
  logic        rd_fire;
  logic [1:0]  rd_resp;
  logic [31:0] rd_value;

  logic [1:0]  bresp_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  genvar g;
  generate
    for (g = 0; g < NUMBER_REG; g++) begin : g_words
      assign stat_words[g]        = statstics[32*g +: 32];
      assign host_data[32*g +: 32] = host_regs[g];
    end
  endgenerate

  // Address decode for both channels. Host and statistics words share the
  // same index bits [5:2]; the bank is selected by the offset range.
  assign wr_off       = offset_of(s_axil_awaddr);
  assign wr_prefix_ok = prefix_match(s_axil_awaddr);
  assign wr_host_hit  = wr_prefix_ok && (wr_off >= HOST_BASE) && (wr_off < HOST_END);
  assign wr_idx       = wr_off[5:2];

  assign rd_off       = offset_of(s_axil_araddr);
  assign rd_prefix_ok = prefix_match(s_axil_araddr);
  assign rd_stat_hit  = rd_prefix_ok && (rd_off < STAT_END);
  assign rd_host_hit  = rd_prefix_ok && (rd_off >= HOST_BASE) && (rd_off < HOST_END);
  assign rd_idx       = rd_off[5:2];

  // Response codes. Without the error feature every access answers OKAY,
  // while the decode still gates which writes update state.
  always_comb begin
    wr_resp = RESP_OKAY;
    rd_resp = RESP_OKAY;
`ifdef REGISTER_READ_ERR_RESP_EN
    if (!wr_prefix_ok)
      wr_resp = RESP_DECERR;
    else if (!wr_host_hit)
      wr_resp = RESP_SLVERR;

    if (!rd_prefix_ok)
      rd_resp = RESP_DECERR;
    else if (!(rd_stat_hit || rd_host_hit))
      rd_resp = RESP_SLVERR;
`endif
  end

  // Read data mux; a miss returns zero.
  always_comb begin
    rd_value = 32'd0;
    for (int i = 0; i < NUMBER_REG; i++) begin
      if (rd_stat_hit && (rd_idx == 4'(i)))
        rd_value = stat_words[i];
      if (rd_host_hit && (rd_idx == 4'(i)))
        rd_value = host_regs[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel: IDLE sees both valids -> ACCEPT raises awready/wready for a
  // single cycle -> RESP holds bvalid until bready. No new write is looked at
  // while the response is outstanding.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn)
      wr_state <= W_IDLE;
    else
      wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:   if (s_axil_awvalid && s_axil_wvalid) wr_next = W_ACCEPT;
      W_ACCEPT: wr_next = wr_fire ? W_RESP : W_IDLE;
      W_RESP:   if (s_axil_bready) wr_next = W_IDLE;
      default:  wr_next = W_IDLE;
    endcase
  end

  assign wr_fire        = (wr_state == W_ACCEPT) && s_axil_awvalid && s_axil_wvalid;
  assign s_axil_awready = (wr_state == W_ACCEPT);
  assign s_axil_wready  = (wr_state == W_ACCEPT);
  assign s_axil_bvalid  = (wr_state == W_RESP);
  assign s_axil_bresp   = bresp_q;

  // Host registers and the write response code are captured at the handshake.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      bresp_q <= RESP_OKAY;
      for (int i = 0; i < NUMBER_REG; i++)
        host_regs[i] <= 32'd0;
    end else if (wr_fire) begin
      bresp_q <= wr_resp;
      for (int i = 0; i < NUMBER_REG; i++)
        if (wr_host_hit && (wr_idx == 4'(i)))
          host_regs[i] <= s_axil_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel: same three-step shape as the write side. Data is captured at
  // the handshake edge, so a simultaneous write to the same host word returns
  // the value held before that write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn)
      rd_state <= R_IDLE;
    else
      rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:   if (s_axil_arvalid) rd_next = R_ACCEPT;
      R_ACCEPT: rd_next = rd_fire ? R_RESP : R_IDLE;
      R_RESP:   if (s_axil_rready) rd_next = R_IDLE;
      default:  rd_next = R_IDLE;
    endcase
  end

  assign rd_fire        = (rd_state == R_ACCEPT) && s_axil_arvalid;
  assign s_axil_arready = (rd_state == R_ACCEPT);
  assign s_axil_rvalid  = (rd_state == R_RESP);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
    end else if (rd_fire) begin
      rdata_q <= rd_value;
      rresp_q <= rd_resp;
    end
  end

endmodule

// File: tb/tb_register_read.sv
// -----------------------------------------------------------------------------
// tb_register_read
//
// Directed bench for register_read with default parameters. A behavioural
// model of the address map (host word array plus the statistics values the
// bench drives) predicts host_data, bresp, rdata and rresp; a negedge compare
// process checks them every cycle they are meaningful, and the directed
// sequences add literal expectations for specific reads and responses.
// -----------------------------------------------------------------------------
module tb_register_read;

  localparam int N = 10;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              s_axil_awvalid;
  logic [31:0]       s_axil_awaddr;
  logic              s_axil_awready;
  logic              s_axil_wvalid;
  logic [31:0]       s_axil_wdata;
  logic              s_axil_wready;
  logic              s_axil_bvalid;
  logic [1:0]        s_axil_bresp;
  logic              s_axil_bready;
  logic              s_axil_arvalid;
  logic [31:0]       s_axil_araddr;
  logic              s_axil_arready;
  logic              s_axil_rvalid;
  logic [31:0]       s_axil_rdata;
  logic [1:0]        s_axil_rresp;
  logic              s_axil_rready;
  logic [32*N-1:0]   statstics;
  logic [32*N-1:0]   host_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_host [N];
  logic [31:0] stat_vals  [N];
  logic [1:0]  exp_bresp;
  logic [1:0]  exp_rresp;
  logic [31:0] exp_rdata;

`ifdef REGISTER_READ_ERR_RESP_EN
  localparam logic [1:0] LIT_SLVERR = 2'b10;
  localparam logic [1:0] LIT_DECERR = 2'b11;
`else
  localparam logic [1:0] LIT_SLVERR = 2'b00;
  localparam logic [1:0] LIT_DECERR = 2'b00;
`endif

  always #5 aclk = ~aclk;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_stat
      assign statstics[32*g +: 32] = stat_vals[g];
    end
  endgenerate

  register_read #(
    .REG_ADDR_W(12),
    .NUMBER_REG(N),
    .REG_PREFIX(0)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awready (s_axil_awready),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bready  (s_axil_bready),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arready (s_axil_arready),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rready  (s_axil_rready),
    .statstics      (statstics),
    .host_data      (host_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of the address map: prefix is bits [31:12] == 0, statistics live at
  // byte offsets 0..39, host words at 64..103.
  function automatic int host_index(input logic [31:0] addr);
    int off;
    if (addr[31:12] != 20'd0) return -1;
    off = int'(addr[11:2]) * 4;
    if (off >= 64 && off < 64 + 4*N) return (off - 64) / 4;
    return -1;
  endfunction

  function automatic int stat_index(input logic [31:0] addr);
    int off;
    if (addr[31:12] != 20'd0) return -1;
    off = int'(addr[11:2]) * 4;
    if (off < 4*N) return off / 4;
    return -1;
  endfunction

  function automatic logic [1:0] model_wresp(input logic [31:0] addr);
    if (addr[31:12] != 20'd0) return LIT_DECERR;
    if (host_index(addr) < 0) return LIT_SLVERR;
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [31:0] addr,
                                     output logic [31:0] d, output logic [1:0] r);
    int hi;
    int si;
    hi = host_index(addr);
    si = stat_index(addr);
    d = 32'd0;
    r = LIT_SLVERR;
    if (addr[31:12] != 20'd0) r = LIT_DECERR;
    else if (hi >= 0) begin d = model_host[hi]; r = 2'b00; end
    else if (si >= 0) begin d = stat_vals[si];  r = 2'b00; end
  endfunction

  // Every-cycle comparison of the DUT against the model.
  always @(negedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N; i++)
        checkOutput($sformatf("host_data[%0d]", i), host_data[32*i +: 32], model_host[i]);
      if (s_axil_bvalid)
        checkOutput("bresp", {30'd0, s_axil_bresp}, {30'd0, exp_bresp});
      if (s_axil_rvalid) begin
        checkOutput("rdata", s_axil_rdata, exp_rdata);
        checkOutput("rresp", {30'd0, s_axil_rresp}, {30'd0, exp_rresp});
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic [31:0] value);
    stat_vals[idx] = value;
  endtask

  // One write; hold>0 keeps bready low that many extra cycles with the write
  // valids still asserted, to show no second accept happens meanwhile.
  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data,
                            input int hold, output logic [1:0] resp);
    bit got;
    int hi;
    resp = 2'bxx;
    @(posedge aclk); #1;
    s_axil_awaddr  = addr;
    s_axil_wdata   = data;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge aclk);
      if (s_axil_awready) got = 1;
    end
    if (!got) begin
      checkOutput("aw_timeout", 32'd0, 32'd1);
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      return;
    end
    checkOutput("wready_with_awready", {31'd0, s_axil_wready}, 32'd1);
    @(posedge aclk); #1;
    hi = host_index(addr);
    if (hi >= 0) model_host[hi] = data;
    exp_bresp = model_wresp(addr);
    if (hold == 0) begin
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
    end
    @(negedge aclk);
    checkOutput("bvalid_rise", {31'd0, s_axil_bvalid}, 32'd1);
    checkOutput("awready_single", {31'd0, s_axil_awready}, 32'd0);
    resp = s_axil_bresp;
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      checkOutput("bvalid_hold", {31'd0, s_axil_bvalid}, 32'd1);
      checkOutput("awready_blocked", {31'd0, s_axil_awready}, 32'd0);
    end
    s_axil_bready = 1'b1;
    @(posedge aclk); #1;
    s_axil_bready  = 1'b0;
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    @(negedge aclk);
    checkOutput("bvalid_fall", {31'd0, s_axil_bvalid}, 32'd0);
  endtask

  task automatic applyRead(input logic [31:0] addr, input logic [31:0] lit_data,
                           input int hold, output logic [1:0] resp);
    bit got;
    resp = 2'bxx;
    @(posedge aclk); #1;
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge aclk);
      if (s_axil_arready) got = 1;
    end
    if (!got) begin
      checkOutput("ar_timeout", 32'd0, 32'd1);
      s_axil_arvalid = 1'b0;
      return;
    end
    // Model sampled at the handshake edge itself, before any write model
    // update that lands #1 later in the same cycle.
    @(posedge aclk);
    model_read(addr, exp_rdata, exp_rresp);
    #1;
    if (hold == 0) s_axil_arvalid = 1'b0;
    @(negedge aclk);
    checkOutput("rvalid_rise", {31'd0, s_axil_rvalid}, 32'd1);
    checkOutput("arready_single", {31'd0, s_axil_arready}, 32'd0);
    checkOutput($sformatf("rdata_lit@%08h", addr), s_axil_rdata, lit_data);
    resp = s_axil_rresp;
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      checkOutput("rvalid_hold", {31'd0, s_axil_rvalid}, 32'd1);
      checkOutput("arready_blocked", {31'd0, s_axil_arready}, 32'd0);
    end
    s_axil_rready = 1'b1;
    @(posedge aclk); #1;
    s_axil_rready  = 1'b0;
    s_axil_arvalid = 1'b0;
    @(negedge aclk);
    checkOutput("rvalid_fall", {31'd0, s_axil_rvalid}, 32'd0);
  endtask

  initial begin
    logic [1:0] resp;
    logic [1:0] resp2;
    bit got;

    aresetn        = 1'b1;
    s_axil_awvalid = 1'b0;
    s_axil_awaddr  = 32'd0;
    s_axil_wvalid  = 1'b0;
    s_axil_wdata   = 32'd0;
    s_axil_bready  = 1'b0;
    s_axil_arvalid = 1'b0;
    s_axil_araddr  = 32'd0;
    s_axil_rready  = 1'b0;
    exp_bresp      = 2'b00;
    exp_rresp      = 2'b00;
    exp_rdata      = 32'd0;
    for (int i = 0; i < N; i++) begin
      model_host[i] = 32'd0;
      stat_vals[i]  = 32'd0;
    end

    #12;
    $display("[TB] reset state");
    checkOutput("rst_awready", {31'd0, s_axil_awready}, 32'd0);
    checkOutput("rst_wready",  {31'd0, s_axil_wready},  32'd0);
    checkOutput("rst_bvalid",  {31'd0, s_axil_bvalid},  32'd0);
    checkOutput("rst_arready", {31'd0, s_axil_arready}, 32'd0);
    checkOutput("rst_rvalid",  {31'd0, s_axil_rvalid},  32'd0);
    checkOutput("rst_bresp",   {30'd0, s_axil_bresp},   32'd0);
    checkOutput("rst_rresp",   {30'd0, s_axil_rresp},   32'd0);
    checkOutput("rst_rdata",   s_axil_rdata,            32'd0);
    checkOutput("rst_host_data_lo", host_data[31:0],    32'd0);
    @(negedge aclk);
    aresetn = 1'b0;

    $display("[TB] host writes and reads");
    for (int i = 0; i < N; i++) begin
      applyWrite(32'h40 + 32'(4*i), 32'(100 + i), 0, resp);
      checkOutput("host_wr_bresp", {30'd0, resp}, 32'd0);
    end
    checkOutput("host_word3_lit", host_data[32*3 +: 32], 32'd103);
    checkOutput("host_word9_lit", host_data[32*9 +: 32], 32'd109);
    for (int i = 0; i < N; i++) begin
      applyRead(32'h40 + 32'(4*i), 32'(100 + i), 0, resp);
      checkOutput("host_rd_rresp", {30'd0, resp}, 32'd0);
    end

    $display("[TB] statistics reads");
    for (int i = 0; i < N; i++) applyStimulus(i, 32'(1000 + i));
    for (int i = 0; i < N; i++) applyRead(32'(4*i), 32'(1000 + i), 0, resp);
    applyStimulus(3, 32'd7);
    applyRead(32'h0C, 32'd7, 0, resp);
    applyRead(32'h0E, 32'd7, 0, resp);

    $display("[TB] write to statistics and misses");
    applyWrite(32'h04, 32'hDEADBEEF, 0, resp);
    checkOutput("stat_wr_bresp", {30'd0, resp}, {30'd0, LIT_SLVERR});
    applyRead(32'h04, 32'd1001, 0, resp);
    applyRead(32'h200, 32'd0, 0, resp);
    checkOutput("miss_rresp", {30'd0, resp}, {30'd0, LIT_SLVERR});
    applyRead(32'h0000_1040, 32'd0, 0, resp);
    checkOutput("prefix_rresp", {30'd0, resp}, {30'd0, LIT_DECERR});
    applyWrite(32'h0000_1044, 32'h1234_5678, 0, resp);
    checkOutput("prefix_wr_bresp", {30'd0, resp}, {30'd0, LIT_DECERR});
    checkOutput("prefix_wr_nochange", host_data[32*1 +: 32], 32'd101);

    $display("[TB] backpressure");
    applyWrite(32'h60, 32'hA5A5_0001, 5, resp);
    applyRead(32'h60, 32'hA5A5_0001, 5, resp);

    $display("[TB] simultaneous read and write of one host word");
    fork
      applyWrite(32'h4C, 32'h55, 0, resp);
      applyRead(32'h4C, 32'd103, 0, resp2);
    join
    applyRead(32'h4C, 32'h55, 0, resp);

    $display("[TB] reset during pending response");
    @(posedge aclk); #1;
    s_axil_awaddr  = 32'h44;
    s_axil_wdata   = 32'h99;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge aclk);
      if (s_axil_awready) got = 1;
    end
    if (!got) checkOutput("aw_timeout_rst", 32'd0, 32'd1);
    @(posedge aclk); #1;
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    if (got) begin
      model_host[1] = 32'h99;
      exp_bresp = 2'b00;
    end
    @(negedge aclk);
    checkOutput("pend_bvalid", {31'd0, s_axil_bvalid}, 32'd1);
    checkOutput("pend_host1", host_data[32*1 +: 32], 32'h99);
    #2;
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) model_host[i] = 32'd0;
    #1;
    checkOutput("async_bvalid", {31'd0, s_axil_bvalid}, 32'd0);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("async_host[%0d]", i), host_data[32*i +: 32], 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    applyWrite(32'h40, 32'h77, 0, resp);
    applyRead(32'h40, 32'h77, 0, resp);
    applyRead(32'h44, 32'd0, 0, resp);

    repeat (2) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
